// File: rtl/mul_seq_pkg.sv
// Shared definitions for the 32x32 multiply sequencer: op codes, FSM states,
// partial-product shift codes and the shift-into-accumulator helper.
package mul_seq_pkg;

  localparam logic [1:0] MUL_OP_LO  = 2'd0;
  localparam logic [1:0] MUL_OP_XUU = 2'd1;
  localparam logic [1:0] MUL_OP_XSS = 2'd2;
  localparam logic [1:0] MUL_OP_XSU = 2'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DRAIN = 3'd2,
    CORR  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [1:0] SH_0  = 2'd0;
  localparam logic [1:0] SH_16 = 2'd1;
  localparam logic [1:0] SH_32 = 2'd2;

  function automatic logic [63:0] shift_prod(input logic [31:0] p, input logic [1:0] sh);
    case (sh)
      SH_16:   return {16'b0, p, 16'b0};
      SH_32:   return {p, 32'b0};
      default: return {32'b0, p};
    endcase
  endfunction

endpackage

// File: rtl/mul_seq_ctrl_mul16_pipe.sv
// 16x16 unsigned multiplier with MUL_LATENCY output register stages.
// aclr clears every stage asynchronously.
module mul16_pipe #(
  parameter int MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        aclr,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);

  logic [31:0] stage [MUL_LATENCY];

  // product enters stage 0, then ripples down the register chain
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      for (int i = 0; i < MUL_LATENCY; i++) stage[i] <= '0;
    end else begin
      stage[0] <= 32'(a) * 32'(b);
      for (int i = 1; i < MUL_LATENCY; i++) stage[i] <= stage[i-1];
    end
  end

  assign p = stage[MUL_LATENCY-1];

endmodule

// File: rtl/mul_seq_ctrl.sv
// 32x32 multiply sequencer built on one pipelined 16x16 unsigned multiplier.
// Optional build macro: MUL_SEQ_SHORT_LO_EN (skip a1*b1 for the low-word op).
//
//   state | meaning
//   IDLE  | ready for a request
//   ISSUE | feeding one partial product per cycle
//   DRAIN | waiting for the last products to leave the multiplier
//   CORR  | signed correction of the high word, result registered
//   DONE  | response held until consumed
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int MUL_LATENCY = 1,
  parameter int OP_W        = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [OP_W-1:0] req_op,
  input  logic [31:0]     req_src1,
  input  logic [31:0]     req_src2,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [31:0]     resp_data
);

  // all tag stages except the output one; DRAIN may leave once these are empty
  localparam logic [MUL_LATENCY-1:0] EARLY_MASK = MUL_LATENCY'((1 << (MUL_LATENCY - 1)) - 1);

  state_t           state, state_nx;
  logic [OP_W-1:0]  op_q;
  logic [31:0]      a_q, b_q;
  logic [63:0]      acc;
  logic [1:0]       issue_cnt;
  logic             issue_en, last_issue, pend_early, aclr;
  logic [15:0]      mul_a, mul_b;
  logic [1:0]       issue_sh;
  logic [31:0]      prod, corr, hi_corr, result;
  logic [MUL_LATENCY-1:0] tag_v;
  logic [1:0]       tag_sh [MUL_LATENCY];

  assign aclr       = ~reset_n;
  assign pend_early = |(tag_v & EARLY_MASK);

`ifdef MUL_SEQ_SHORT_LO_EN
  assign last_issue = (issue_cnt == 2'd3) || ((op_q == OP_W'(MUL_OP_LO)) && (issue_cnt == 2'd2));
`else
  assign last_issue = (issue_cnt == 2'd3);
`endif

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // next-state logic; flush wins over everything outside IDLE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = ISSUE;
      ISSUE:   if (flush) state_nx = IDLE; else if (last_issue) state_nx = DRAIN;
      DRAIN:   if (flush) state_nx = IDLE; else if (!pend_early) state_nx = CORR;
      CORR:    state_nx = flush ? IDLE : DONE;
      DONE:    if (flush || resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == DONE);
    issue_en   = (state == ISSUE) && !flush;
  end

  // operand halves and shift tag for the current partial product
  always_comb begin
    case (issue_cnt)
      2'd0:    begin mul_a = a_q[15:0];  mul_b = b_q[15:0];  issue_sh = SH_0;  end
      2'd1:    begin mul_a = a_q[31:16]; mul_b = b_q[15:0];  issue_sh = SH_16; end
      2'd2:    begin mul_a = a_q[15:0];  mul_b = b_q[31:16]; issue_sh = SH_16; end
      default: begin mul_a = a_q[31:16]; mul_b = b_q[31:16]; issue_sh = SH_32; end
    endcase
  end

  // signed correction of the high word and result-word selection
  always_comb begin
    corr = '0;
    if (op_q == OP_W'(MUL_OP_XSS))
      corr = (a_q[31] ? b_q : 32'd0) + (b_q[31] ? a_q : 32'd0);
    else if (op_q == OP_W'(MUL_OP_XSU))
      corr = a_q[31] ? b_q : 32'd0;
    hi_corr = acc[63:32] - corr;
    result  = (op_q == OP_W'(MUL_OP_LO)) ? acc[31:0] : hi_corr;
  end

  mul16_pipe #(.MUL_LATENCY(MUL_LATENCY)) u_mul (
    .clk  (clk),
    .aclr (aclr),
    .a    (mul_a),
    .b    (mul_b),
    .p    (prod)
  );

  // shift tags travel alongside the multiplier stages; flush invalidates them
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_v <= '0;
      for (int i = 0; i < MUL_LATENCY; i++) tag_sh[i] <= SH_0;
    end else if (flush && (state != IDLE)) begin
      tag_v <= '0;
    end else begin
      tag_v[0]  <= issue_en;
      tag_sh[0] <= issue_sh;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_sh[i] <= tag_sh[i-1];
      end
    end
  end

  // operand capture, issue counter, accumulation and result register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      issue_cnt <= '0;
      resp_data <= '0;
    end else if ((state == IDLE) && req_valid) begin
      op_q      <= req_op;
      a_q       <= req_src1;
      b_q       <= req_src2;
      acc       <= '0;
      issue_cnt <= '0;
    end else begin
      if (issue_en) issue_cnt <= issue_cnt + 2'd1;
      if (tag_v[MUL_LATENCY-1]) begin
        acc <= acc + shift_prod(prod, tag_sh[MUL_LATENCY-1]);
      end else if ((state == CORR) && !flush) begin
        acc[63:32] <= hi_corr;
        resp_data  <= result;
      end
    end
  end

endmodule
